uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one UART transmit FIFO (the FIFO feeding the uart bit transmitter) between NUM_REQ byte-stream requesters.
- Once a requester is granted, it owns the FIFO until its last byte. With HEADER_EN, a source-ID header byte is written ahead of each packet.
- A stalled owner is evicted after TIMEOUT_CYC idle cycles and an error pulse is raised.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- HEADER_EN, 1, 1 = insert header byte {4'hA, id[3:0]} before each packet; 0 = no header.
- TIMEOUT_CYC, 1024, consecutive cycles the owner's valid may stay low mid-packet before eviction; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; TIMEOUT_CYC < 2^TO_W.

Ports:
- clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- iv_req_valid  input  NUM_REQ  per-requester byte valid
- iv_req_data  input  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k]
- iv_req_last  input  NUM_REQ  marks the final byte of the packet; qualified by valid
- ov_req_ready  output  NUM_REQ  per-requester ready (combinational)
- o_fifo_wr  output  1  FIFO write strobe (combinational)
- ov_fifo_din  output  8  FIFO write data (combinational)
- i_fifo_full  input  1  FIFO full
- ov_grant  output  NUM_REQ  one-hot current owner, registered; all zero in IDLE
- o_busy  output  1  high when state is not IDLE
- o_timeout_err  output  1  one-clk pulse on eviction
- ov_timeout_src  output  4  index of the evicted requester; holds until the next eviction

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, ov_grant = 0, rr pointer = NUM_REQ-1 (so requester 0 has first priority).
  - Timeout counter = 0, o_timeout_err = 0, ov_timeout_src = 0.
  - All ready/write outputs = 0.
- Reset mid-packet: the packet is abandoned and nothing further is written. The FIFO may hold a partial packet; that is the system's concern.
- FSM states: IDLE, HEADER, DATA.
- IDLE:
  - If any iv_req_valid bit is set, grant the first valid requester searching upward from rr pointer+1, wrapping modulo NUM_REQ.
  - Register the grant. Next state is HEADER if HEADER_EN, else DATA.
  - No FIFO writes and no ready in IDLE, so there is at least one IDLE cycle between packets.
- HEADER:
  - o_fifo_wr = !i_fifo_full; ov_fifo_din = {4'hA, id[3:0]}.
  - Move to DATA on the cycle the write occurs; stay in HEADER while full.
- DATA:
  - ov_req_ready[g] = !i_fifo_full for the granted index g; all other ready bits are 0.
  - A transfer happens when valid[g] && ready[g]. On a transfer, o_fifo_wr = 1 and ov_fifo_din = data[g] in the same cycle.
  - Transfer with last[g] set: go to IDLE, rr pointer = g, grant cleared.
  - The owner's valid/data/last must stay stable until ready. Valid from non-owners is ignored, and non-owners see ready = 0.
- Timeout (DATA only, TIMEOUT_CYC != 0):
  - The counter increments each cycle valid[g] = 0 and clears on any cycle valid[g] = 1.
  - Cycles where the owner is valid but the FIFO is full do not count.
  - When the counter reaches TIMEOUT_CYC-1 while valid[g] is still 0: next cycle o_timeout_err = 1 for one clk, ov_timeout_src = g, state = IDLE, rr pointer = g.
  - No trailer byte is written on eviction.
- Boundary conditions:
  - A single-byte packet (last on the first byte) is legal.
  - i_fifo_full rising in the same cycle as a pending transfer: ready is 0, so no write occurs. o_fifo_wr is never asserted while i_fifo_full = 1.
  - All requesters valid continuously: grants rotate 0,1,2,3,0... one packet each.
  - rr pointer wraps from NUM_REQ-1 to 0.
  - Header id is the grant index zero-extended to 4 bits.

Test Plan:
- Reset, then req1 sends 3 bytes 0x11,0x22,0x33 with last on 0x33 (HEADER_EN=1) -> FIFO receives 0xA1,0x11,0x22,0x33; ov_grant=4'b0010 during the packet; o_busy falls the cycle after 0x33.
- All four requesters valid with 2-byte packets -> grant order 0,1,2,3,0; exactly one IDLE cycle between packets; no interleaving of bytes between sources.
- i_fifo_full held high for 5 cycles mid-packet -> o_fifo_wr = 0 and ready = 0 throughout; transfer resumes on the first non-full cycle with no byte lost or duplicated.
- Owner drops valid after 1 byte, TIMEOUT_CYC=8 -> o_timeout_err pulses once, 8 cycles after valid falls; ov_timeout_src = owner id; the next requester is granted; the counter does not advance while full && valid.
- HEADER_EN=0, req0 single-byte packet 0x5A -> FIFO receives only 0x5A; grant returns to IDLE after one data cycle.
- Assert i_reset_n low mid-DATA -> all outputs go to 0 immediately (async); after release, requester 0 has first priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that lets NUM_REQ byte
// streams share a single UART transmit FIFO.
//
// Handshake: a byte moves from requester g to the FIFO in the cycle where
// iv_req_valid[g] && ov_req_ready[g]. Ready is only ever offered to the
// current owner, and only while the FIFO is not full. In that same cycle
// o_fifo_wr is high and ov_fifo_din carries the byte. The owner must hold
// valid/data/last steady until ready is seen. Valid on a non-owner is only
// used to choose the next owner in IDLE.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter bit HEADER_EN   = 1'b1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 16
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   iv_req_valid,
  input  logic [NUM_REQ*8-1:0] iv_req_data,
  input  logic [NUM_REQ-1:0]   iv_req_last,
  output logic [NUM_REQ-1:0]   ov_req_ready,
  output logic                 o_fifo_wr,
  output logic [7:0]           ov_fifo_din,
  input  logic                 i_fifo_full,
  output logic [NUM_REQ-1:0]   ov_grant,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic [3:0]           ov_timeout_src,
  output logic [1:0]           ov_dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  // Counter value on the last tolerated idle cycle; unused when disabled.
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_to_err;
  logic [3:0]         r_to_src;

  logic               w_hi_any;
  logic [IDX_W-1:0]   w_hi_idx;
  logic               w_lo_any;
  logic [IDX_W-1:0]   w_lo_idx;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_oh;

  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic [3:0]         w_hdr_id;
  logic               w_xfer;
  logic               w_evict;

  // Round-robin pick: lowest valid index above the pointer, else lowest valid
  // index overall (this is the wrap back through requester 0).
  always_comb begin
    w_hi_any  = 1'b0;
    w_hi_idx  = '0;
    w_lo_any  = 1'b0;
    w_lo_idx  = '0;
    w_pick_oh = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (iv_req_valid[k]) begin
        w_lo_any = 1'b1;
        w_lo_idx = IDX_W'(k);
        if (IDX_W'(k) > r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDX_W'(k);
        end
      end
    end
    w_pick_any = w_lo_any;
    w_pick_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pick_oh[k] = (IDX_W'(k) == w_pick_idx);
    end
  end

  // Select the owner's valid/last/data using the one-hot grant.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_own_valid = iv_req_valid[k];
        w_own_last  = iv_req_last[k];
        w_own_data  = iv_req_data[k*8 +: 8];
      end
    end
  end

  // Header id is the owner index zero-extended to a nibble.
  assign w_hdr_id = 4'(r_gnt_idx);

  // FSM state register.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and combinational FIFO/ready outputs.
  always_comb begin
    w_state_nxt  = r_state;
    ov_req_ready = '0;
    o_fifo_wr    = 1'b0;
    ov_fifo_din  = '0;
    w_xfer       = 1'b0;
    w_evict      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = HEADER_EN ? ST_HEADER : ST_DATA;
        end
      end
      ST_HEADER: begin
        o_fifo_wr   = !i_fifo_full;
        ov_fifo_din = {4'hA, w_hdr_id};
        if (!i_fifo_full) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        ov_req_ready = i_fifo_full ? '0 : r_grant;
        w_xfer       = w_own_valid && !i_fifo_full;
        if (w_xfer) begin
          o_fifo_wr   = 1'b1;
          ov_fifo_din = w_own_data;
          if (w_own_last) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (TO_EN && !w_own_valid && (r_to_cnt == TO_LAST)) begin
          // Owner has been silent long enough: drop it without a trailer.
          w_evict     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant and round-robin pointer: set on pick, released on last byte or eviction.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant   <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
    end else if ((r_state == ST_IDLE) && w_pick_any) begin
      r_grant   <= w_pick_oh;
      r_gnt_idx <= w_pick_idx;
    end else if ((w_xfer && w_own_last) || w_evict) begin
      r_grant  <= '0;
      r_rr_ptr <= r_gnt_idx;
    end
  end

  // Idle counter: counts owner-invalid cycles in DATA; any valid cycle clears it.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_to_cnt <= '0;
    end else if (TO_EN && (r_state == ST_DATA) && !w_own_valid && !w_evict) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Eviction report: one-cycle pulse, source index held until the next one.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_to_err <= 1'b0;
      r_to_src <= '0;
    end else begin
      r_to_err <= w_evict;
      if (w_evict) begin
        r_to_src <= 4'(r_gnt_idx);
      end
    end
  end

  assign ov_grant       = r_grant;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_timeout_err  = r_to_err;
  assign ov_timeout_src = r_to_src;
  assign ov_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level reference model, random traffic,
// directed timeout / no-header / mid-packet reset cases.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TO   = 8;
  localparam int MAXB = 64;
  localparam int EW   = 13;  // {last, src[3:0], byte}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_reset_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic           fifo_full;
  logic [N-1:0]   ov_req_ready;
  logic           o_fifo_wr;
  logic [7:0]     ov_fifo_din;
  logic [N-1:0]   ov_grant;
  logic           o_busy;
  logic           o_timeout_err;
  logic [3:0]     ov_timeout_src;
  logic [1:0]     ov_dbg_state;

  logic [N-1:0]   nh_valid;
  logic [N*8-1:0] nh_data;
  logic [N-1:0]   nh_last;
  logic [N-1:0]   nh_ready;
  logic           nh_wr;
  logic [7:0]     nh_din;
  logic [N-1:0]   nh_grant;
  logic           nh_busy;
  logic           nh_err;
  logic [3:0]     nh_src;
  logic [1:0]     nh_dbg;

  uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1'b1), .TIMEOUT_CYC(TO), .TO_W(16)) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .iv_req_valid(req_valid), .iv_req_data(req_data), .iv_req_last(req_last),
    .ov_req_ready(ov_req_ready), .o_fifo_wr(o_fifo_wr), .ov_fifo_din(ov_fifo_din),
    .i_fifo_full(fifo_full), .ov_grant(ov_grant), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err), .ov_timeout_src(ov_timeout_src),
    .ov_dbg_state(ov_dbg_state)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1'b0), .TIMEOUT_CYC(0), .TO_W(16)) dut_nh (
    .clk(clk), .i_reset_n(i_reset_n),
    .iv_req_valid(nh_valid), .iv_req_data(nh_data), .iv_req_last(nh_last),
    .ov_req_ready(nh_ready), .o_fifo_wr(nh_wr), .ov_fifo_din(nh_din),
    .i_fifo_full(1'b0), .ov_grant(nh_grant), .o_busy(nh_busy),
    .o_timeout_err(nh_err), .ov_timeout_src(nh_src),
    .ov_dbg_state(nh_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] exp_q[$];
  int m_rr;

  logic [8:0] stim_mem [N][MAXB];  // {last, byte}
  int stim_cnt [N];
  int stim_pos [N];
  int gap [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    i_reset_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    nh_valid  = '0; nh_data  = '0; nh_last  = '0;
    repeat (3) @(posedge clk);
    #1 i_reset_n = 1'b1;
    m_rr = N - 1;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_cnt[k] = 0;
      stim_pos[k] = 0;
      gap[k]      = 0;
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] b, input logic l);
    stim_mem[k][stim_cnt[k]] = {l, b};
    stim_cnt[k]++;
  endtask

  task automatic present();
    for (int k = 0; k < N; k++) begin
      if (gap[k] == 0 && stim_pos[k] < stim_cnt[k]) begin
        req_valid[k]        = 1'b1;
        req_data[k*8 +: 8]  = stim_mem[k][stim_pos[k]][7:0];
        req_last[k]         = stim_mem[k][stim_pos[k]][8];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[k*8 +: 8]  = 8'h00;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  // Packet-level model: whole packets leave in round-robin order among the
  // requesters that still hold packets, each preceded by its header byte.
  task automatic build_expect();
    int pos [N];
    int pick;
    logic [8:0] e;
    for (int k = 0; k < N; k++) pos[k] = stim_pos[k];
    while (1) begin
      pick = -1;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (pick < 0 && pos[k] < stim_cnt[k]) pick = k;
      end
      if (pick < 0) break;
      exp_q.push_back({1'b0, 4'(pick), 4'hA, 4'(pick)});
      do begin
        e = stim_mem[pick][pos[pick]];
        exp_q.push_back({e[8], 4'(pick), e[7:0]});
        pos[pick]++;
      end while (!e[8]);
      m_rr = pick;
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [3:0] idx);
    logic [N-1:0] oh;
    for (int j = 0; j < N; j++) oh[j] = (4'(j) == idx);
    return oh;
  endfunction

  // Runs queued stimulus until the model stream drains, checking every cycle.
  task automatic run_phase(input int full_pct, input int gap_pct, input int fs, input int fl);
    int cyc = 0;
    int tail = 3;
    logic [N-1:0] hs;
    bit pend_idle = 1'b0;
    bit pend_busy = 1'b0;
    logic [EW-1:0] e;
    logic sent_last;
    build_expect();
    present();
    fifo_full = (cyc >= fs && cyc < fs + fl) || ($urandom_range(99) < full_pct);
    while (cyc < 2000) begin
      @(negedge clk);
      if (pend_busy) begin
        check_eq("one_idle_busy", 32'(o_busy), 32'(1));
        pend_busy = 1'b0;
      end
      if (pend_idle) begin
        check_eq("idle_busy", 32'(o_busy), 32'(0));
        check_eq("idle_grant", 32'(ov_grant), 32'(0));
        pend_idle = 1'b0;
        pend_busy = (exp_q.size() > 0);
      end
      if (fifo_full) begin
        check_eq("wr_while_full", 32'(o_fifo_wr), 32'(0));
        check_eq("rdy_while_full", 32'(ov_req_ready), 32'(0));
      end
      check_eq("rdy_non_owner", 32'(ov_req_ready & ~ov_grant), 32'(0));
      if (o_fifo_wr) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_wr", 32'(o_fifo_wr), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("fifo_din", 32'(ov_fifo_din), 32'(e[7:0]));
          check_eq("wr_grant", 32'(ov_grant), 32'(onehot(e[11:8])));
          if (e[12]) pend_idle = 1'b1;
        end
      end
      hs = req_valid & ov_req_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (hs[k]) begin
          sent_last = stim_mem[k][stim_pos[k]][8];
          stim_pos[k]++;
          if (!sent_last && $urandom_range(99) < gap_pct) gap[k] = $urandom_range(1, 3);
        end else if (gap[k] > 0) begin
          gap[k]--;
        end
      end
      present();
      cyc++;
      fifo_full = (cyc >= fs && cyc < fs + fl) || ($urandom_range(99) < full_pct);
      if (exp_q.size() == 0 && !pend_idle && !pend_busy) begin
        if (tail == 0) break;
        tail--;
      end
    end
    check_eq("phase_drained", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    fifo_full = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_reset_n = 1'b0;
    req_valid = '1; req_data = '0; req_last = '0; fifo_full = 1'b0;
    nh_valid  = '1; nh_data  = '0; nh_last  = '0;
    m_rr = N - 1;
    clear_stim();

    // Reset state with every requester asking.
    @(negedge clk);
    check_eq("rst_grant", 32'(ov_grant), 32'(0));
    check_eq("rst_busy", 32'(o_busy), 32'(0));
    check_eq("rst_err", 32'(o_timeout_err), 32'(0));
    check_eq("rst_src", 32'(ov_timeout_src), 32'(0));
    check_eq("rst_ready", 32'(ov_req_ready), 32'(0));
    check_eq("rst_wr", 32'(o_fifo_wr), 32'(0));
    check_eq("rst_nh_wr", 32'(nh_wr), 32'(0));

    // Requester 1 sends 11,22,33.
    reset_dut();
    clear_stim();
    add_byte(1, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b0);
    add_byte(1, 8'h33, 1'b1);
    run_phase(0, 0, 0, 0);

    // All four requesters with 2-byte packets; requester 0 has two.
    reset_dut();
    clear_stim();
    for (int k = 0; k < N; k++) begin
      add_byte(k, 8'($urandom), 1'b0);
      add_byte(k, 8'($urandom), 1'b1);
    end
    add_byte(0, 8'hE0, 1'b0);
    add_byte(0, 8'hE1, 1'b1);
    run_phase(0, 0, 0, 0);

    // FIFO full for 5 cycles in the middle of a 6-byte packet.
    clear_stim();
    for (int b = 0; b < 6; b++) add_byte(2, 8'(8'h60 + b), b == 5);
    run_phase(0, 0, 4, 5);

    // Random traffic with FIFO back-pressure and short owner gaps.
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), b == len - 1);
        end
      end
      run_phase(25, 30, 0, 0);
    end

    // Timeout: owner 1 stalls on full (no count), sends a byte, then goes silent.
    reset_dut();
    req_valid = 4'b0010; req_data[15:8] = 8'h01; req_last = '0;
    @(negedge clk);
    check_eq("to_idle_busy", 32'(o_busy), 32'(0));
    tick();
    @(negedge clk);
    check_eq("to_hdr", 32'(ov_fifo_din), 32'(8'hA1));
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("to_full_no_err", 32'(o_timeout_err), 32'(0));
      check_eq("to_full_busy", 32'(o_busy), 32'(1));
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check_eq("to_byte_wr", 32'(o_fifo_wr), 32'(1));
    check_eq("to_byte", 32'(ov_fifo_din), 32'(8'h01));
    tick();
    req_valid = 4'b0101;
    req_data  = '0; req_data[7:0] = 8'h0F; req_data[23:16] = 8'h77;
    req_last  = 4'b0101;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check_eq("to_wait_err", 32'(o_timeout_err), 32'(0));
      check_eq("to_wait_busy", 32'(o_busy), 32'(1));
      tick();
    end
    @(negedge clk);
    check_eq("to_err", 32'(o_timeout_err), 32'(1));
    check_eq("to_src", 32'(ov_timeout_src), 32'(1));
    check_eq("to_evict_idle", 32'(o_busy), 32'(0));
    check_eq("to_no_trailer", 32'(o_fifo_wr), 32'(0));
    tick();
    @(negedge clk);
    check_eq("to_err_pulse", 32'(o_timeout_err), 32'(0));
    check_eq("to_next_grant", 32'(ov_grant), 32'(4'b0100));
    check_eq("to_next_hdr", 32'(ov_fifo_din), 32'(8'hA2));
    tick();
    @(negedge clk);
    check_eq("to_next_byte", 32'(ov_fifo_din), 32'(8'h77));
    check_eq("to_src_hold", 32'(ov_timeout_src), 32'(1));
    tick();
    req_valid = '0;

    // No-header instance: single-byte packet 5A from requester 0.
    reset_dut();
    nh_valid = 4'b0001; nh_data[7:0] = 8'h5A; nh_last = 4'b0001;
    @(negedge clk);
    check_eq("nh_idle_wr", 32'(nh_wr), 32'(0));
    check_eq("nh_idle_busy", 32'(nh_busy), 32'(0));
    tick();
    @(negedge clk);
    check_eq("nh_wr", 32'(nh_wr), 32'(1));
    check_eq("nh_din", 32'(nh_din), 32'(8'h5A));
    check_eq("nh_grant", 32'(nh_grant), 32'(4'b0001));
    check_eq("nh_ready", 32'(nh_ready), 32'(4'b0001));
    tick();
    nh_valid = '0;
    @(negedge clk);
    check_eq("nh_after_wr", 32'(nh_wr), 32'(0));
    check_eq("nh_after_busy", 32'(nh_busy), 32'(0));
    check_eq("nh_after_grant", 32'(nh_grant), 32'(0));

    // Reset in the middle of a packet from requester 3.
    reset_dut();
    clear_stim();
    add_byte(2, 8'h21, 1'b1);
    run_phase(0, 0, 0, 0);
    req_valid = 4'b1001; req_data = '0; req_data[7:0] = 8'h0C; req_data[31:24] = 8'h3C;
    req_last  = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("mr_grant3", 32'(ov_grant), 32'(4'b1000));
    check_eq("mr_hdr3", 32'(ov_fifo_din), 32'(8'hA3));
    tick();
    @(negedge clk);
    check_eq("mr_data3", 32'(ov_fifo_din), 32'(8'h3C));
    #2 i_reset_n = 1'b0;
    #1;
    check_eq("mr_async_grant", 32'(ov_grant), 32'(0));
    check_eq("mr_async_busy", 32'(o_busy), 32'(0));
    check_eq("mr_async_wr", 32'(o_fifo_wr), 32'(0));
    check_eq("mr_async_ready", 32'(ov_req_ready), 32'(0));
    check_eq("mr_async_err", 32'(o_timeout_err), 32'(0));
    @(posedge clk);
    #1 i_reset_n = 1'b1;
    @(negedge clk);
    check_eq("mr_rel_idle", 32'(o_busy), 32'(0));
    tick();
    @(negedge clk);
    check_eq("mr_prio0", 32'(ov_grant), 32'(4'b0001));
    check_eq("mr_hdr0", 32'(ov_fifo_din), 32'(8'hA0));
    tick();
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
